// File: rtl/beam_prb_pwr_if.sv
// rtl/beam_prb_pwr_if.sv - beam-sum input stream and PRB power result bundle
interface beam_prb_pwr_if #(
  parameter int IW = 32,
  parameter int OW = 40
);
  logic [IW-1:0] i_sum_data;
  logic          i_rvalid;
  logic          i_sop;
  logic [OW-1:0] o_prb_pwr;
  logic [7:0]    o_prb_idx;
  logic          o_pvalid;
  logic          o_last;
  logic          o_err;
  logic [OW-1:0] o_peak_pwr;
  logic [7:0]    o_peak_idx;

  modport master (
    output i_sum_data, i_rvalid, i_sop,
    input  o_prb_pwr, o_prb_idx, o_pvalid, o_last, o_err, o_peak_pwr, o_peak_idx
  );

  modport slave (
    input  i_sum_data, i_rvalid, i_sop,
    output o_prb_pwr, o_prb_idx, o_pvalid, o_last, o_err, o_peak_pwr, o_peak_idx
  );
endinterface

// File: rtl/beam_prb_pwr.sv
// rtl/beam_prb_pwr.sv - per-PRB |x|^2 integrator; BEAM_PRB_PEAK_EN builds the per-symbol peak tracker
module beam_prb_pwr #(
  parameter int IW         = 32,
  parameter int RE_PER_PRB = 12,
  parameter int NUM_PRB    = 40,
  parameter int OW         = 40
) (
  input logic           i_clk,
  input logic           reset,
  beam_prb_pwr_if.slave bus
);
  localparam int HW  = IW / 2;
  localparam int SQW = 2 * HW - 1;
  localparam int SW  = 2 * HW;
  localparam int AW  = 35;
  localparam int CW  = (RE_PER_PRB > 1) ? $clog2(RE_PER_PRB) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_ACC
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] re_cnt;
  logic [CW-1:0] re_cnt_nxt;
  logic [CW-1:0] re_pos;
  logic [7:0]    prb_cnt;
  logic [7:0]    prb_cnt_nxt;
  logic [7:0]    prb_pos;
  logic          re_err;
  logic          re_first;
  logic          re_last;
  logic          prb_last;

  logic signed [SW-1:0] re_ext;
  logic signed [SW-1:0] im_ext;
  logic [SQW-1:0]       re_sq;
  logic [SQW-1:0]       im_sq;

  logic           s1_valid;
  logic [SQW-1:0] s1_re2;
  logic [SQW-1:0] s1_im2;
  logic           s1_first;
  logic           s1_last;
  logic           s1_prb_last;
  logic           s1_err;
  logic [7:0]     s1_prb;

  logic           s2_valid;
  logic [SW-1:0]  s2_sum;
  logic           s2_first;
  logic           s2_last;
  logic           s2_prb_last;
  logic           s2_err;
  logic [7:0]     s2_prb;

  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_base;
  logic [AW-1:0]  acc_sum;

  logic [OW-1:0]  prb_pwr_q;
  logic [7:0]     prb_idx_q;
  logic           pvalid_q;
  logic           last_q;
  logic           err_q;

  // Control state register and RE/PRB position counters
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      re_cnt  <= '0;
      prb_cnt <= '0;
    end else begin
      state   <= state_nxt;
      re_cnt  <= re_cnt_nxt;
      prb_cnt <= prb_cnt_nxt;
    end
  end

  // Decide where the incoming RE lands (RE/PRB position) and whether a sop truncates a partial PRB
  always_comb begin
    state_nxt   = state;
    re_cnt_nxt  = re_cnt;
    prb_cnt_nxt = prb_cnt;
    re_pos      = re_cnt;
    prb_pos     = prb_cnt;
    re_err      = 1'b0;
    if (bus.i_rvalid) begin
      case (state)
        ST_IDLE: begin
          re_pos    = '0;
          prb_pos   = '0;
          state_nxt = ST_ACC;
        end
        default: begin
          if (bus.i_sop) begin
            re_err  = (re_cnt != '0);
            re_pos  = '0;
            prb_pos = '0;
          end
        end
      endcase
      if (re_pos == CW'(RE_PER_PRB - 1)) begin
        re_cnt_nxt  = '0;
        prb_cnt_nxt = (prb_pos == 8'(NUM_PRB - 1)) ? 8'd0 : prb_pos + 8'd1;
      end else begin
        re_cnt_nxt  = re_pos + CW'(1);
        prb_cnt_nxt = prb_pos;
      end
    end
  end

  assign re_first = (re_pos == '0);
  assign re_last  = (re_pos == CW'(RE_PER_PRB - 1));
  assign prb_last = (prb_pos == 8'(NUM_PRB - 1));

  // Squares fit in SQW bits even for -32768^2, so the truncation drops only zero bits
  assign re_ext = {{HW{bus.i_sum_data[IW-1]}}, bus.i_sum_data[IW-1:HW]};
  assign im_ext = {{HW{bus.i_sum_data[HW-1]}}, bus.i_sum_data[HW-1:0]};
  assign re_sq  = SQW'(re_ext * re_ext);
  assign im_sq  = SQW'(im_ext * im_ext);

  // Stage 1: register re^2, im^2 with the RE's position tags
  always_ff @(posedge i_clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_re2      <= '0;
      s1_im2      <= '0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_prb_last <= 1'b0;
      s1_err      <= 1'b0;
      s1_prb      <= '0;
    end else begin
      s1_valid <= bus.i_rvalid;
      if (bus.i_rvalid) begin
        s1_re2      <= re_sq;
        s1_im2      <= im_sq;
        s1_first    <= re_first;
        s1_last     <= re_last;
        s1_prb_last <= prb_last;
        s1_err      <= re_err;
        s1_prb      <= prb_pos;
      end
    end
  end

  // Stage 2: register |x|^2 = re^2 + im^2
  always_ff @(posedge i_clk) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      s2_sum      <= '0;
      s2_first    <= 1'b0;
      s2_last     <= 1'b0;
      s2_prb_last <= 1'b0;
      s2_err      <= 1'b0;
      s2_prb      <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum      <= {1'b0, s1_re2} + {1'b0, s1_im2};
        s2_first    <= s1_first;
        s2_last     <= s1_last;
        s2_prb_last <= s1_prb_last;
        s2_err      <= s1_err;
        s2_prb      <= s1_prb;
      end
    end
  end

  // RE 0 of a PRB starts from zero, which also discards any partial PRB cut short by a sop
  assign acc_base = s2_first ? '0 : acc;
  assign acc_sum  = acc_base + AW'(s2_sum);

  // Stage 3: integrate, and emit the PRB word when its last RE arrives
  always_ff @(posedge i_clk) begin
    if (reset) begin
      acc       <= '0;
      prb_pwr_q <= '0;
      prb_idx_q <= '0;
      pvalid_q  <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pvalid_q <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      if (s2_valid) begin
        err_q <= s2_err;
        if (s2_last) begin
          prb_pwr_q <= OW'(acc_sum);
          prb_idx_q <= s2_prb;
          pvalid_q  <= 1'b1;
          last_q    <= s2_prb_last;
          acc       <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  assign bus.o_prb_pwr = prb_pwr_q;
  assign bus.o_prb_idx = prb_idx_q;
  assign bus.o_pvalid  = pvalid_q;
  assign bus.o_last    = last_q;
  assign bus.o_err     = err_q;

`ifdef BEAM_PRB_PEAK_EN
  logic [AW-1:0] trk_pwr;
  logic [7:0]    trk_idx;
  logic          trk_take;
  logic [AW-1:0] trk_pwr_nxt;
  logic [7:0]    trk_idx_nxt;
  logic [OW-1:0] peak_pwr_q;
  logic [7:0]    peak_idx_q;

  // PRB 0 opens a fresh symbol; strict compare keeps the lowest index on ties
  assign trk_take    = (s2_prb == 8'd0) || (acc_sum > trk_pwr);
  assign trk_pwr_nxt = trk_take ? acc_sum : trk_pwr;
  assign trk_idx_nxt = trk_take ? s2_prb : trk_idx;

  // Track the strongest PRB and publish it with the symbol's last PRB
  always_ff @(posedge i_clk) begin
    if (reset) begin
      trk_pwr    <= '0;
      trk_idx    <= '0;
      peak_pwr_q <= '0;
      peak_idx_q <= '0;
    end else if (s2_valid && s2_last) begin
      trk_pwr <= trk_pwr_nxt;
      trk_idx <= trk_idx_nxt;
      if (s2_prb_last) begin
        peak_pwr_q <= OW'(trk_pwr_nxt);
        peak_idx_q <= trk_idx_nxt;
      end
    end else if (s2_valid && s2_first && s2_prb == 8'd0) begin
      trk_pwr <= '0;
      trk_idx <= '0;
    end
  end

  assign bus.o_peak_pwr = peak_pwr_q;
  assign bus.o_peak_idx = peak_idx_q;
`else
  assign bus.o_peak_pwr = '0;
  assign bus.o_peak_idx = '0;
`endif

endmodule

// File: tb/tb_beam_prb_pwr.sv
// tb/tb_beam_prb_pwr.sv - scoreboard bench for beam_prb_pwr against a PRB power model
module tb_beam_prb_pwr;
  localparam int IW   = 32;
  localparam int OW   = 40;
  localparam int RPP  = 12;
  localparam int NPRB = 40;

  logic i_clk = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  beam_prb_pwr_if #(.IW(IW), .OW(OW)) bus ();

  beam_prb_pwr #(.IW(IW), .RE_PER_PRB(RPP), .NUM_PRB(NPRB), .OW(OW)) dut (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [OW-1:0] pwr;
    logic [7:0]    idx;
    bit            last;
    logic [OW-1:0] pk_pwr;
    logic [7:0]    pk_idx;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  int     m_re_cnt;
  int     m_prb;
  longint m_acc;
  longint m_sym[NPRB];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    m_re_cnt = 0;
    m_prb    = 0;
    m_acc    = 0;
  endtask

  // Reference: sum of re^2+im^2 over RPP consecutive valid REs, restarted by sop
  task automatic model_step(input int re, input int im, input bit sop, input int c);
    exp_t e;
    longint pk;
    int pki;
    if (sop) begin
      if (m_re_cnt != 0) begin
        e = '{is_err: 1'b1, pwr: '0, idx: '0, last: 1'b0, pk_pwr: '0, pk_idx: '0, cyc: c + 3};
        sb.push_back(e);
      end
      m_re_cnt = 0;
      m_acc    = 0;
      m_prb    = 0;
    end
    m_acc += longint'(re) * longint'(re) + longint'(im) * longint'(im);
    m_re_cnt++;
    if (m_re_cnt == RPP) begin
      m_sym[m_prb] = m_acc;
      pk  = m_sym[0];
      pki = 0;
      for (int i = 1; i <= m_prb; i++) begin
        if (m_sym[i] > pk) begin
          pk  = m_sym[i];
          pki = i;
        end
      end
      e = '{is_err: 1'b0, pwr: OW'(m_acc), idx: 8'(m_prb), last: (m_prb == NPRB - 1),
            pk_pwr: OW'(pk), pk_idx: 8'(pki), cyc: c + 3};
      sb.push_back(e);
      m_acc    = 0;
      m_re_cnt = 0;
      m_prb    = (m_prb == NPRB - 1) ? 0 : m_prb + 1;
    end
  endtask

  task automatic send(input int re, input int im, input bit sop);
    logic [15:0] r16;
    logic [15:0] i16;
    r16 = 16'(re);
    i16 = 16'(im);
    @(posedge i_clk);
    #1;
    bus.i_sum_data = {r16, i16};
    bus.i_rvalid   = 1'b1;
    bus.i_sop      = sop;
    model_step(re, im, sop, cyc);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
      bus.i_rvalid   = 1'b0;
      bus.i_sop      = 1'($urandom_range(0, 1));
      bus.i_sum_data = $urandom;
    end
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    idle(1);
    while (sb.size() != 0 && w < 30) begin
      idle(1);
      w++;
    end
    idle(2);
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_pwr"}, 64'(bus.o_prb_pwr), 64'd0);
    chk({nm, "_idx"}, 64'(bus.o_prb_idx), 64'd0);
    chk({nm, "_pvalid"}, 64'(bus.o_pvalid), 64'd0);
    chk({nm, "_last"}, 64'(bus.o_last), 64'd0);
    chk({nm, "_err"}, 64'(bus.o_err), 64'd0);
    chk({nm, "_peak_pwr"}, 64'(bus.o_peak_pwr), 64'd0);
    chk({nm, "_peak_idx"}, 64'(bus.o_peak_idx), 64'd0);
  endtask

  // Monitor: every output event pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!reset && (bus.o_pvalid || bus.o_err)) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL unexpected_output: pvalid=%0b err=%0b idx=%0d pwr=%0d, required none",
                   bus.o_pvalid, bus.o_err, bus.o_prb_idx, bus.o_prb_pwr);
        end else begin
          e = sb.pop_front();
          chk("cycle", 64'(cyc), 64'(e.cyc));
          chk("pvalid", 64'(bus.o_pvalid), 64'(!e.is_err));
          chk("err", 64'(bus.o_err), 64'(e.is_err));
          if (!e.is_err) begin
            chk("prb_pwr", 64'(bus.o_prb_pwr), 64'(e.pwr));
            chk("prb_idx", 64'(bus.o_prb_idx), 64'(e.idx));
            chk("last", 64'(bus.o_last), 64'(e.last));
`ifdef BEAM_PRB_PEAK_EN
            if (e.last) begin
              chk("peak_pwr", 64'(bus.o_peak_pwr), 64'(e.pk_pwr));
              chk("peak_idx", 64'(bus.o_peak_idx), 64'(e.pk_idx));
            end
`else
            chk("peak_pwr_off", 64'(bus.o_peak_pwr), 64'd0);
            chk("peak_idx_off", 64'(bus.o_peak_idx), 64'd0);
`endif
          end
        end
      end
      if (!reset && bus.o_last && !bus.o_pvalid) begin
        n_chk++;
        n_bad++;
        $display("FAIL stray_last: last=1 pvalid=0, required last only with pvalid");
      end
    end
  end

  initial begin
    int rv;
    int iv;
    bus.i_sum_data = '0;
    bus.i_rvalid   = 1'b0;
    bus.i_sop      = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_outputs_zero("reset");
    @(posedge i_clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Unit power per RE: PRB 0 = 12
    for (int i = 0; i < RPP; i++) send(1, 0, i == 0);
    drain("t1_drain");

    // Full-scale negative corner: 12 * 2^31 without wrap
    for (int i = 0; i < RPP; i++) send(-32768, -32768, 1'b0);
    drain("t2_drain");

    // Full symbol with gaps, then one more PRB that wraps to idx 0
    for (int i = 0; i < RPP * NPRB; i++) begin
      maybe_gap();
      send(i % 7, -3, i == 0);
    end
    for (int i = 0; i < RPP; i++) send(i, i + 1, 1'b0);
    drain("t3_drain");

    // Mid-PRB sop discards 5 REs and restarts PRB 0
    for (int i = 0; i < 5; i++) send(100 + i, 7, 1'b0);
    for (int i = 0; i < RPP; i++) send(int'($urandom_range(0, 2000)) - 1000, 9, i == 0);
    drain("t4_drain");

    // Reset after 7 REs: nothing emitted, then fresh PRB 0
    for (int i = 0; i < 7; i++) send(3000, -2000, 1'b0);
    @(posedge i_clk);
    #1;
    reset        = 1'b1;
    bus.i_rvalid = 1'b0;
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs_zero("midreset");
    @(posedge i_clk);
    #1;
    reset = 1'b0;
    idle(3);
    for (int i = 0; i < RPP; i++) send(i * 11, -i, 1'b0);
    drain("t5_drain");

    // Symbol with tied maxima at PRBs 3 and 17
    for (int p = 0; p < NPRB; p++) begin
      for (int r = 0; r < RPP; r++) begin
        maybe_gap();
        if (p == 3 || p == 17) begin
          rv = 1000;
          iv = -1000;
        end else begin
          rv = int'($urandom_range(0, 1000)) - 500;
          iv = int'($urandom_range(0, 1000)) - 500;
        end
        send(rv, iv, p == 0 && r == 0);
      end
    end
    drain("t6_drain");

    // Random full-range REs with occasional sop and gaps
    for (int i = 0; i < 400; i++) begin
      maybe_gap();
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 39) == 0);
    end
    drain("t7_drain");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
